// File: rtl/rank_topk_sorter.sv
// Streaming top-K selection sorter: loads up to DEPTH {key,id} pairs, then
// repeatedly scans the stored frame for the best unselected entry and emits it.
module rank_topk_sorter #(
    parameter int KEY_W  = 32,
    parameter int ID_W   = 16,
    parameter int DEPTH  = 32,
    parameter int K      = DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_desc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    input  logic [ID_W-1:0]  in_id,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic [ID_W-1:0]  out_id,
    output logic             out_last,
    output logic             busy
);

    localparam int               CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] K_C    = CNT_W'(K);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  emitted_q, emitted_d;
    logic [CNT_W-1:0]  scan_q, scan_d;
    logic [DEPTH-1:0]  sel_q, sel_d;
    logic              mode_q, mode_d;
    logic              best_vld_q, best_vld_d;
    logic [ADDR_W-1:0] best_idx_q, best_idx_d;
    logic [KEY_W-1:0]  best_key_q, best_key_d;
    logic [ID_W-1:0]   best_id_q, best_id_d;
    logic              out_valid_q, out_valid_d;
    logic [KEY_W-1:0]  out_key_q, out_key_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_last_q, out_last_d;

    logic [KEY_W-1:0]  key_mem [DEPTH];
    logic [ID_W-1:0]   id_mem  [DEPTH];

    logic              accept_s;
    logic [ADDR_W-1:0] scan_addr_s;
    logic [KEY_W-1:0]  scan_key_s;
    logic [ID_W-1:0]   scan_id_s;
    logic              better_s;
    logic              take_s;
    logic              scan_done_s;
    logic [CNT_W-1:0]  k_eff_s;

    assign accept_s    = (state_q == ST_LOAD) && in_valid;
    assign scan_addr_s = scan_q[ADDR_W-1:0];
    assign scan_key_s  = key_mem[scan_addr_s];
    assign scan_id_s   = id_mem[scan_addr_s];
    // Strict comparison so an equal key never displaces the earlier arrival.
    assign better_s    = mode_q ? (scan_key_s > best_key_q) : (scan_key_s < best_key_q);
    assign take_s      = !sel_q[scan_addr_s] && (!best_vld_q || better_s);
    assign scan_done_s = (scan_q == (count_q - ONE_C));
    assign k_eff_s     = (K_C < count_q) ? K_C : count_q;

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;

    // Entry storage; contents are qualified by count/mask so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            key_mem[count_q[ADDR_W-1:0]] <= in_key;
            id_mem[count_q[ADDR_W-1:0]]  <= in_id;
        end
    end

    // Next-state and datapath decode for LOAD/SCAN/EMIT.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        emitted_d   = emitted_q;
        scan_d      = scan_q;
        sel_d       = sel_q;
        mode_d      = mode_q;
        best_vld_d  = best_vld_q;
        best_idx_d  = best_idx_q;
        best_key_d  = best_key_q;
        best_id_d   = best_id_q;
        out_valid_d = out_valid_q;
        out_key_d   = out_key_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    count_d = count_q + ONE_C;
                    if (count_q == {CNT_W{1'b0}}) begin
                        mode_d = cfg_desc;
                    end else begin
                        mode_d = mode_q;
                    end
                    if (in_last || (count_q == LAST_C)) begin
                        state_d    = ST_SCAN;
                        scan_d     = {CNT_W{1'b0}};
                        best_vld_d = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            ST_SCAN: begin
                if (take_s) begin
                    best_vld_d = 1'b1;
                    best_idx_d = scan_addr_s;
                    best_key_d = scan_key_s;
                    best_id_d  = scan_id_s;
                end else begin
                    best_vld_d = best_vld_q;
                end
                if (scan_done_s) begin
                    state_d     = ST_EMIT;
                    out_valid_d = 1'b1;
                    out_key_d   = take_s ? scan_key_s : best_key_q;
                    out_id_d    = take_s ? scan_id_s : best_id_q;
                    out_last_d  = ((emitted_q + ONE_C) == k_eff_s);
                end else begin
                    scan_d = scan_q + ONE_C;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d   = ST_LOAD;
                        count_d   = {CNT_W{1'b0}};
                        sel_d     = {DEPTH{1'b0}};
                        emitted_d = {CNT_W{1'b0}};
                    end else begin
                        state_d           = ST_SCAN;
                        scan_d            = {CNT_W{1'b0}};
                        best_vld_d        = 1'b0;
                        sel_d[best_idx_q] = 1'b1;
                        emitted_d         = emitted_q + ONE_C;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                count_d     = {CNT_W{1'b0}};
                sel_d       = {DEPTH{1'b0}};
                emitted_d   = {CNT_W{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            count_q     <= {CNT_W{1'b0}};
            emitted_q   <= {CNT_W{1'b0}};
            scan_q      <= {CNT_W{1'b0}};
            sel_q       <= {DEPTH{1'b0}};
            mode_q      <= 1'b0;
            best_vld_q  <= 1'b0;
            best_idx_q  <= {ADDR_W{1'b0}};
            best_key_q  <= {KEY_W{1'b0}};
            best_id_q   <= {ID_W{1'b0}};
            out_valid_q <= 1'b0;
            out_key_q   <= {KEY_W{1'b0}};
            out_id_q    <= {ID_W{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            emitted_q   <= emitted_d;
            scan_q      <= scan_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            best_vld_q  <= best_vld_d;
            best_idx_q  <= best_idx_d;
            best_key_q  <= best_key_d;
            best_id_q   <= best_id_d;
            out_valid_q <= out_valid_d;
            out_key_q   <= out_key_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_rank_topk_sorter.sv
// Bench for rank_topk_sorter: table vectors, hand sequences for the multi-cycle
// corners, and random frames against a stable-sort reference model.
module tb_rank_topk_sorter;

    localparam int KW    = 32;
    localparam int IW    = 16;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]    cfg_desc, in_valid, in_ready, in_last;
    logic [1:0]    out_valid, out_ready, out_last, busy;
    logic [KW-1:0] in_key [2];
    logic [KW-1:0] out_key [2];
    logic [IW-1:0] in_id [2];
    logic [IW-1:0] out_id [2];

    rank_topk_sorter #(.KEY_W(KW), .ID_W(IW), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .reset(reset), .cfg_desc(cfg_desc[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_key(in_key[0]),
        .in_id(in_id[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_key(out_key[0]), .out_id(out_id[0]),
        .out_last(out_last[0]), .busy(busy[0])
    );

    rank_topk_sorter #(.KEY_W(KW), .ID_W(IW), .DEPTH(DEPTH), .K(2)) u_dut1 (
        .clk(clk), .reset(reset), .cfg_desc(cfg_desc[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_key(in_key[1]),
        .in_id(in_id[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_key(out_key[1]), .out_id(out_id[1]),
        .out_last(out_last[1]), .busy(busy[1])
    );

    typedef struct {
        int                 u;
        int                 n;
        bit                 desc;
        logic [7:0][KW-1:0] key;
        logic [7:0][IW-1:0] id;
        int                 en;
        logic [7:0][KW-1:0] ekey;
        logic [7:0][IW-1:0] eid;
    } vec_t;

    vec_t vt[5];

    int n_chk  = 0;
    int n_fail = 0;

    logic [KW-1:0] fk [DEPTH];
    logic [IW-1:0] fi [DEPTH];
    logic [KW-1:0] ek [DEPTH];
    logic [IW-1:0] ei [DEPTH];
    int            en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: stable sort by key in the frame's direction, then keep the first min(K,n).
    task automatic model(input int u, input int n, input bit desc);
        int ord[DEPTH];
        int tmp;
        int kk;
        for (int i = 0; i < n; i++) ord[i] = i;
        for (int i = 1; i < n; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (fk[ord[j]] > fk[ord[j-1]]) : (fk[ord[j]] < fk[ord[j-1]])) begin
                    tmp = ord[j]; ord[j] = ord[j-1]; ord[j-1] = tmp;
                end else begin
                    break;
                end
            end
        end
        kk = (u == 0) ? DEPTH : 2;
        en = (n < kk) ? n : kk;
        for (int c = 0; c < en; c++) begin
            ek[c] = fk[ord[c]];
            ei[c] = fi[ord[c]];
        end
    endtask

    task automatic send_frame(input int u, input int n, input bit desc, input bit last_on_final);
        chk("in_ready_before_frame", 64'(in_ready[u]), 64'(1));
        for (int b = 0; b < n; b++) begin
            in_valid[u] = 1'b1;
            in_key[u]   = fk[b];
            in_id[u]    = fi[b];
            in_last[u]  = (b == n - 1) && last_on_final;
            cfg_desc[u] = (b == 0) ? desc : !desc;
            @(posedge clk); #1;
        end
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic wait_valid(input int u, input int lim, output int cyc);
        cyc = 0;
        while (!out_valid[u] && cyc < lim) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic collect(input int u, input int rdy_pct);
        int got;
        int budget;
        bit rdy;
        got    = 0;
        budget = 4000;
        while (got < en && budget > 0) begin
            rdy          = ($urandom_range(0, 99) < rdy_pct);
            out_ready[u] = rdy;
            if (out_valid[u] && rdy) begin
                chk("out_key", 64'(out_key[u]), 64'(ek[got]));
                chk("out_id", 64'(out_id[u]), 64'(ei[got]));
                chk("out_last", 64'(out_last[u]), 64'(got == en - 1));
                got++;
            end
            @(posedge clk); #1;
            budget--;
        end
        out_ready[u] = 1'b0;
        chk("result_count", 64'(got), 64'(en));
        chk("end_in_ready", 64'(in_ready[u]), 64'(1));
        chk("end_busy", 64'(busy[u]), 64'(0));
        chk("end_out_valid", 64'(out_valid[u]), 64'(0));
    endtask

    task automatic reset_checks(input int u);
        chk("rst_in_ready", 64'(in_ready[u]), 64'(1));
        chk("rst_out_valid", 64'(out_valid[u]), 64'(0));
        chk("rst_out_key", 64'(out_key[u]), 64'(0));
        chk("rst_out_id", 64'(out_id[u]), 64'(0));
        chk("rst_out_last", 64'(out_last[u]), 64'(0));
        chk("rst_busy", 64'(busy[u]), 64'(0));
    endtask

    initial begin
        int cyc;
        int u;
        int n;
        bit desc;
        bit lastf;

        // Table entries: element 0 is the rightmost in each concatenation.
        vt[0].u = 0; vt[0].n = 5; vt[0].desc = 1'b1; vt[0].en = 5;
        vt[0].key  = {32'd0, 32'd0, 32'd0, 32'd3, 32'd9, 32'd1, 32'd9, 32'd5};
        vt[0].id   = {16'd0, 16'd0, 16'd0, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        vt[0].ekey = {32'd0, 32'd0, 32'd0, 32'd1, 32'd3, 32'd5, 32'd9, 32'd9};
        vt[0].eid  = {16'd0, 16'd0, 16'd0, 16'd2, 16'd4, 16'd0, 16'd3, 16'd1};
        vt[1].u = 1; vt[1].n = 4; vt[1].desc = 1'b0; vt[1].en = 2;
        vt[1].key  = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd2, 32'd7};
        vt[1].id   = {16'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0};
        vt[1].ekey = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0};
        vt[1].eid  = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd3};
        vt[2].u = 0; vt[2].n = 1; vt[2].desc = 1'b1; vt[2].en = 1;
        vt[2].key  = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        vt[2].id   = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hABCD};
        vt[2].ekey = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        vt[2].eid  = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hABCD};
        vt[3].u = 0; vt[3].n = 4; vt[3].desc = 1'b0; vt[3].en = 4;
        vt[3].key  = {32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd1, 32'd3, 32'd3};
        vt[3].id   = {16'd0, 16'd0, 16'd0, 16'd0, 16'd13, 16'd12, 16'd11, 16'd10};
        vt[3].ekey = {32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd3, 32'd3, 32'd1};
        vt[3].eid  = {16'd0, 16'd0, 16'd0, 16'd0, 16'd13, 16'd11, 16'd10, 16'd12};
        vt[4].u = 1; vt[4].n = 3; vt[4].desc = 1'b1; vt[4].en = 2;
        vt[4].key  = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
        vt[4].id   = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 16'd8, 16'd7};
        vt[4].ekey = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
        vt[4].eid  = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd8, 16'd7};

        reset     = 1'b1;
        cfg_desc  = 2'b00;
        in_valid  = 2'b00;
        in_last   = 2'b00;
        out_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            in_key[i] = 32'd0;
            in_id[i]  = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset_checks(0);
        reset_checks(1);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < vt[v].n; b++) begin
                fk[b] = vt[v].key[b];
                fi[b] = vt[v].id[b];
            end
            en = vt[v].en;
            for (int c = 0; c < en; c++) begin
                ek[c] = vt[v].ekey[c];
                ei[c] = vt[v].eid[c];
            end
            send_frame(vt[v].u, vt[v].n, vt[v].desc, 1'b1);
            collect(vt[v].u, (v == 0) ? 100 : 60);
        end

        // Full frame with no in_last: scan starts after the DEPTH-th beat.
        for (int b = 0; b < DEPTH; b++) begin
            fk[b] = $urandom;
            fi[b] = IW'(b + 100);
        end
        send_frame(0, DEPTH, 1'b1, 1'b0);
        chk("t3_busy", 64'(busy[0]), 64'(1));
        chk("t3_in_ready", 64'(in_ready[0]), 64'(0));
        in_valid[0] = 1'b1;
        in_last[0]  = 1'b1;
        in_key[0]   = 32'hDEAD_BEEF;
        wait_valid(0, 100, cyc);
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        chk("t3_latency", 64'(cyc + 1), 64'(DEPTH + 1));
        model(0, DEPTH, 1'b1);
        collect(0, 100);

        // Back-pressure: held result must not move for 10 cycles.
        fk[0] = 32'd20; fk[1] = 32'd50; fk[2] = 32'd10;
        fi[0] = 16'd0;  fi[1] = 16'd1;  fi[2] = 16'd2;
        send_frame(0, 3, 1'b1, 1'b1);
        wait_valid(0, 100, cyc);
        for (int c = 0; c < 10; c++) begin
            chk("t5_valid", 64'(out_valid[0]), 64'(1));
            chk("t5_key", 64'(out_key[0]), 64'(50));
            chk("t5_id", 64'(out_id[0]), 64'(1));
            chk("t5_last", 64'(out_last[0]), 64'(0));
            @(posedge clk); #1;
        end
        model(0, 3, 1'b1);
        collect(0, 100);

        // Reset in the scan for the second result; next frame must be clean.
        fk[0] = 32'd100; fk[1] = 32'd300; fk[2] = 32'd200;
        fi[0] = 16'd0;   fi[1] = 16'd1;   fi[2] = 16'd2;
        send_frame(0, 3, 1'b1, 1'b1);
        wait_valid(0, 100, cyc);
        chk("t6_first_key", 64'(out_key[0]), 64'(300));
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_mid_scan_busy", 64'(busy[0]), 64'(1));
        reset = 1'b1;
        #1;
        reset_checks(0);
        @(posedge clk); #1;
        reset = 1'b0;
        fk[0] = 32'd4; fk[1] = 32'd8;
        fi[0] = 16'd5; fi[1] = 16'd6;
        send_frame(0, 2, 1'b1, 1'b1);
        en = 2;
        ek[0] = 32'd8; ei[0] = 16'd6;
        ek[1] = 32'd4; ei[1] = 16'd5;
        collect(0, 100);

        // Random frames against the reference model.
        for (int r = 0; r < 12; r++) begin
            u     = r % 2;
            n     = $urandom_range(1, DEPTH);
            desc  = 1'($urandom_range(0, 1));
            lastf = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int b = 0; b < n; b++) begin
                fk[b] = (r < 6) ? KW'($urandom_range(0, 7)) : KW'($urandom);
                fi[b] = IW'($urandom);
            end
            send_frame(u, n, desc, lastf);
            model(u, n, desc);
            collect(u, 70);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
